mole_scheduler: RTL

- Sequences the whack-a-mole play phase: while the game FSM asserts play_flag, lights one mole at a time and times each mole against a per-mole timeout.
- Scores hits, misses and the reaction time of each correct hit.
- Emits mole_complete back to the game FSM and game_done after a fixed number of rounds.
- Sits between the game FSM, the debounced button inputs and the LED/score display logic.

---
 rtl/mole_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole play-phase sequencer: lights one random mole at a time, times it
// against a timeout, and keeps hit/miss/reaction scores for the display logic.
module mole_scheduler #(
    parameter int          NUM_MOLES = 8,
    parameter int          MOLE_MS   = 1000,
    parameter int          GAP_MS    = 300,
    parameter int          ROUNDS    = 20,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 play_flag,
    input  logic                 ms_tick,
    input  logic [NUM_MOLES-1:0] hit,
    output logic [NUM_MOLES-1:0] mole_on,
    output logic                 mole_complete,
    output logic [7:0]           hits,
    output logic [7:0]           misses,
    output logic [15:0]          reaction_ms,
    output logic                 game_done
);

    localparam int          IDX_W     = $clog2(NUM_MOLES);
    localparam logic [15:0] MOLE_LAST = 16'(MOLE_MS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_MS - 1);
    localparam logic [7:0]  ROUND_MAX = 8'(ROUNDS);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [15:0]            timer_q, timer_d;
    logic [7:0]             round_q, round_d;
    logic [IDX_W-1:0]       prev_idx_q, prev_idx_d;
    logic [NUM_MOLES-1:0]   mole_on_q, mole_on_d;
    logic                   mole_complete_q, mole_complete_d;
    logic [7:0]             hits_q, hits_d;
    logic [7:0]             misses_q, misses_d;
    logic [15:0]            reaction_q, reaction_d;
    logic                   game_done_q, game_done_d;
    logic [IDX_W-1:0]       sel_idx;
    logic [7:0]             misses_inc;

    always_comb begin
        sel_idx = lfsr_q[IDX_W-1:0];
        if (sel_idx == prev_idx_q) begin
            sel_idx = sel_idx + 1'b1;
        end
        misses_inc = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
    end

    always_comb begin
        state_d         = state_q;
        lfsr_d          = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_TAPS);
        timer_d         = timer_q;
        round_d         = round_q;
        prev_idx_d      = prev_idx_q;
        mole_on_d       = mole_on_q;
        mole_complete_d = 1'b0;
        hits_d          = hits_q;
        misses_d        = misses_q;
        reaction_d      = reaction_q;
        game_done_d     = game_done_q;

        case (state_q)
            IDLE: begin
                mole_on_d   = '0;
                game_done_d = 1'b0;
                if (play_flag) begin
                    state_d    = GAP;
                    hits_d     = '0;
                    misses_d   = '0;
                    reaction_d = '0;
                    round_d    = '0;
                    timer_d    = '0;
                end
            end
            GAP: begin
                mole_on_d = '0;
                if (!play_flag) begin
                    state_d = IDLE;
                end else if (ms_tick) begin
                    if (timer_q == GAP_LAST) begin
                        prev_idx_d = sel_idx;
                        timer_d    = '0;
                        state_d    = SHOW;
                        mole_on_d  = {{(NUM_MOLES-1){1'b0}}, 1'b1} << sel_idx;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end
            SHOW: begin
                if (!play_flag) begin
                    state_d   = IDLE;
                    mole_on_d = '0;
                end else if (hit[prev_idx_q] || (ms_tick && timer_q == MOLE_LAST)) begin
                    // A correct hit wins over a coincident timeout
                    if (hit[prev_idx_q]) begin
                        hits_d     = hits_q + 8'd1;
                        reaction_d = timer_q;
                    end else begin
                        misses_d = misses_inc;
                    end
                    mole_complete_d = 1'b1;
                    mole_on_d       = '0;
                    timer_d         = '0;
                    round_d         = round_q + 8'd1;
                    if (round_q + 8'd1 == ROUND_MAX) begin
                        state_d     = DONE;
                        game_done_d = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    if (|hit) begin
                        misses_d = misses_inc;
                    end
                    if (ms_tick) begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end
            DONE: begin
                mole_on_d   = '0;
                game_done_d = 1'b1;
                if (!play_flag) begin
                    state_d     = IDLE;
                    game_done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            lfsr_q          <= LFSR_SEED;
            timer_q         <= '0;
            round_q         <= '0;
            prev_idx_q      <= '0;
            mole_on_q       <= '0;
            mole_complete_q <= 1'b0;
            hits_q          <= '0;
            misses_q        <= '0;
            reaction_q      <= '0;
            game_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            timer_q         <= timer_d;
            round_q         <= round_d;
            prev_idx_q      <= prev_idx_d;
            mole_on_q       <= mole_on_d;
            mole_complete_q <= mole_complete_d;
            hits_q          <= hits_d;
            misses_q        <= misses_d;
            reaction_q      <= reaction_d;
            game_done_q     <= game_done_d;
        end
    end

    assign mole_on       = mole_on_q;
    assign mole_complete = mole_complete_q;
    assign hits          = hits_q;
    assign misses        = misses_q;
    assign reaction_ms   = reaction_q;
    assign game_done     = game_done_q;

endmodule
